// File: rtl/gray_arb_pkg.sv
// Shared types and defaults for the gray-image read-port arbiter.
// Burst mode is enabled by defining GRAY_ARB_BURST_EN.
package gray_arb_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 3;

  typedef enum logic {
    PORT_LBP = 1'b0,
    PORT_AUX = 1'b1
  } port_id_t;

  typedef struct packed {
    logic     vld;
    port_id_t tag;
  } ret_t;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_LBP) ? PORT_AUX : PORT_LBP;
  endfunction

endpackage

// File: rtl/gray_port_arbiter_rr_pick2.sv
// Two-way round-robin pick with an optional lock that pins
// the grant to one port while that port keeps requesting.
module rr_pick2
  import gray_arb_pkg::*;
(
  input  logic       en,
  input  logic [1:0] req,
  input  port_id_t   last,
  input  logic       lock,
  input  port_id_t   lock_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (!en) begin
      gnt = 2'b00;
    end else if (lock && req[lock_id]) begin
      gnt[lock_id] = 1'b1;
    end else if (&req) begin
      gnt[other_port(last)] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/gray_port_arbiter.sv
// Shares the gray-image memory read port between two consumers.
// GRAY_ARB_BURST_EN keeps the winner for up to BURST_MAX beats.
module gray_port_arbiter
  import gray_arb_pkg::*;
#(
  parameter int ADDR_W    = gray_arb_pkg::ADDR_W,
  parameter int DATA_W    = gray_arb_pkg::DATA_W,
  parameter int BURST_MAX = gray_arb_pkg::BURST_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy
);

  if (BURST_MAX < 1) begin : g_bad_burst_max
    $error("BURST_MAX must be at least 1");
  end

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;
  port_id_t          sel;
  logic [ADDR_W-1:0] addr_sel;
  logic              lock;

  port_id_t          last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  port_id_t          tag_q, tag_d;
  ret_t              ret_q, ret_d;

  assign req = {req1, req0};

  rr_pick2 u_pick (
    .en      (mem_ready),
    .req     (req),
    .last    (last_q),
    .lock    (lock),
    .lock_id (last_q),
    .gnt     (gnt)
  );

  assign accept   = |(req & gnt);
  assign sel      = gnt[1] ? PORT_AUX : PORT_LBP;
  assign addr_sel = gnt[1] ? addr1 : addr0;

`ifdef GRAY_ARB_BURST_EN
  localparam int CW = $clog2(BURST_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count saturates so a lone owner hands over as soon as
  // the other port asks.
  assign lock = (cnt_q != '0) && (cnt_q < CW'(BURST_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (!mem_ready) begin
      cnt_d = '0;
    end else if (accept) begin
      if (sel != last_q)
        cnt_d = CW'(1);
      else if (cnt_q < CW'(BURST_MAX))
        cnt_d = cnt_q + 1'b1;
    end else if (!req[last_q]) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    last_d     = last_q;
    mem_req_d  = accept;
    mem_addr_d = mem_addr_q;
    tag_d      = tag_q;
    if (accept) begin
      last_d     = sel;
      mem_addr_d = addr_sel;
      tag_d      = sel;
    end
    ret_d.vld = mem_req_q;
    ret_d.tag = tag_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= PORT_AUX;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      tag_q      <= PORT_LBP;
      ret_q      <= '{vld: 1'b0, tag: PORT_LBP};
    end else begin
      last_q     <= last_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      tag_q      <= tag_d;
      ret_q      <= ret_d;
    end
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  assign rvalid0 = ret_q.vld && (ret_q.tag == PORT_LBP);
  assign rvalid1 = ret_q.vld && (ret_q.tag == PORT_AUX);
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;
  assign busy    = mem_req_q | ret_q.vld;

endmodule

// File: tb/tb_gray_port_arbiter.sv
// Directed plus random stimulus for gray_port_arbiter against a
// cycle-indexed transaction model and a behavioural memory.
module tb_gray_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int BM = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_ready = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;

  always #5 clk = ~clk;

  gray_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0),
    .rvalid1(rvalid1), .rdata1(rdata1),
    .busy(busy)
  );

  logic [7:0] mem [0:16383];

  always @(posedge clk)
    if (mem_req) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Transaction model: acceptance recorded against the cycle
  // in which the resulting mem_req must be visible.
  int cyc = 0;
  int last_m = 1;
  int streak = 0;
  int cur_addr = 0;
  int won = -1;
  int acc_port [int];
  int acc_addr [int];
  int order_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick();
    logic own_req;
    if (!mem_ready) return -1;
    own_req = (last_m == 0) ? req0 : req1;
`ifdef GRAY_ARB_BURST_EN
    if (streak > 0 && streak < BM && own_req) return last_m;
`endif
    if (req0 && req1) return 1 - last_m;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic cycle_step();
    int w, p;
    logic er;
    logic [7:0] ed0, ed1;
    @(negedge clk);
    w  = pick();
    er = acc_port.exists(cyc);
    p  = acc_port.exists(cyc - 1) ? acc_port[cyc - 1] : -1;
    ed0 = (p == 0) ? mem[acc_addr[cyc - 1]] : 8'h00;
    ed1 = (p == 1) ? mem[acc_addr[cyc - 1]] : 8'h00;
    chk("gnt0", gnt0, w == 0);
    chk("gnt1", gnt1, w == 1);
    chk("mem_req", mem_req, er);
    chk("mem_addr", mem_addr, cur_addr);
    chk("rvalid0", rvalid0, p == 0);
    chk("rvalid1", rvalid1, p == 1);
    chk("rdata0", rdata0, ed0);
    chk("rdata1", rdata1, ed1);
    chk("busy", busy, er || p >= 0);
    @(posedge clk);
    won = w;
    if (!mem_ready) begin
      streak = 0;
    end else if (w >= 0) begin
      streak = (w == last_m) ? ((streak < BM) ? streak + 1 : BM) : 1;
    end else if (!((last_m == 0) ? req0 : req1)) begin
      streak = 0;
    end
    if (w >= 0) begin
      acc_port[cyc + 1] = w;
      acc_addr[cyc + 1] = (w == 0) ? int'(addr0) : int'(addr1);
      cur_addr = acc_addr[cyc + 1];
      last_m = w;
      order_q.push_back(w);
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    acc_port.delete();
    acc_addr.delete();
    last_m = 1;
    streak = 0;
    cur_addr = 0;
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic both_run(input int n, input int base0,
                          input int base1);
    int i0, i1;
    i0 = base0;
    i1 = base1;
    addr0 = AW'(i0);
    addr1 = AW'(i1);
    req0 = 1'b1;
    req1 = 1'b1;
    order_q.delete();
    for (int k = 0; k < n; k++) begin
      cycle_step();
      if (won == 0) begin i0++; addr0 = AW'(i0); end
      if (won == 1) begin i1++; addr1 = AW'(i1); end
    end
  endtask

  initial begin
    int exp_o;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom_range(255));

    do_reset();

    // Memory not ready: both request but nothing moves.
    mem_ready = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (5) cycle_step();

    // Single requester, back-to-back addresses 0,1,2.
    mem_ready = 1'b1;
    req1 = 1'b0;
    for (int a = 0; a < 3; a++) begin
      addr0 = AW'(a);
      cycle_step();
      chk("single_won", won, 0);
    end
    req0 = 1'b0;
    repeat (3) cycle_step();

    // Continuous contention.
    do_reset();
    mem_ready = 1'b1;
    both_run(12, 128, 5000);
`ifdef GRAY_ARB_BURST_EN
    for (int k = 0; k < 9; k++) begin
      exp_o = ((k / BM) % 2 == 0) ? 0 : 1;
      chk("burst_order", order_q[k], exp_o);
    end
`else
    for (int k = 0; k < 9; k++)
      chk("alt_order", order_q[k], k % 2);
`endif
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) cycle_step();

    // Port 0 drops after one beat; port 1 must take over.
    both_run(1, 300, 6000);
    req0 = 1'b0;
    cycle_step();
    chk("drop_switch", won, 1);
    req0 = 1'b1;
    repeat (4) cycle_step();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) cycle_step();

    // Ready falls right after an acceptance.
    req0 = 1'b1;
    addr0 = AW'(77);
    cycle_step();
    chk("pre_fall_won", won, 0);
    mem_ready = 1'b0;
    req1 = 1'b1;
    addr1 = AW'(9000);
    repeat (3) cycle_step();
    req0 = 1'b0;
    req1 = 1'b0;
    mem_ready = 1'b1;
    cycle_step();

    // Reset in the cycle after an acceptance.
    req1 = 1'b1;
    addr1 = AW'(4321);
    cycle_step();
    chk("pre_rst_won", won, 1);
    do_reset();
    repeat (3) cycle_step();

    // Random traffic; addresses held until accepted.
    for (int k = 0; k < 300; k++) begin
      mem_ready = ($urandom_range(9) != 0);
      if (!req0 || won == 0) begin
        req0 = ($urandom_range(3) != 0);
        addr0 = AW'($urandom_range(16383));
      end
      if (!req1 || won == 1) begin
        req1 = ($urandom_range(3) != 0);
        addr1 = AW'($urandom_range(16383));
      end
      cycle_step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) cycle_step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
